// File: rtl/req_enc_pkg.sv
// Shared constants and state encoding for the sequential 8-to-3 request encoder.
// Optional round-robin selection is enabled by defining REQ_ENC_RR_EN.
package req_enc_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LAST  = 2'd2
    } state_t;
endpackage

// File: rtl/req_encoder8_prio_enc8.sv
// Find-first-set over 8 request bits, searching upward from a start offset and
// wrapping through 7 to 0.
module prio_enc8
    import req_enc_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    logic [IDX_W-1:0] probe;

    // Scan from the farthest position down so the nearest hit to start wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        probe = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            probe = start + IDX_W'(i);
            if (vec[probe]) begin
                idx   = probe;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/req_encoder8.sv
// Sequential 8-to-3 encoder: accepts a request batch and issues each set index
// over a valid/ready slot. Define REQ_ENC_RR_EN for round-robin selection.
module req_encoder8
    import req_enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req_in,
    input  logic             req_valid,
    output logic             req_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_REQ-1:0] pending,
    output logic             err_empty
);
    // state | meaning
    // IDLE  | nothing pending, output slot empty
    // ISSUE | pending holds at least one unissued request
    // LAST  | pending empty, final index still waiting in the output slot
    state_t state;

    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic [IDX_W-1:0] search_start;
    logic             accept;
    logic             slot_free;
    logic             issue;
    logic [N_REQ-1:0] pending_nxt;
    logic             out_valid_nxt;

`ifdef REQ_ENC_RR_EN
    logic [IDX_W-1:0] last_idx;
    assign search_start = last_idx + 3'd1;
`else
    assign search_start = '0;
`endif

    prio_enc8 u_prio (
        .vec   (pending),
        .start (search_start),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // ISSUE is exactly the pending != 0 condition.
    assign req_ready = en && !rst && (state != ISSUE);
    assign accept    = req_valid && req_ready;
    assign slot_free = !out_valid || out_ready;
    assign issue     = en && slot_free && sel_found;

    always_comb begin
        pending_nxt = pending;
        if (accept)
            pending_nxt = req_in;
        else if (issue)
            pending_nxt = pending & ~(8'd1 << sel_idx);

        out_valid_nxt = out_valid;
        if (issue)
            out_valid_nxt = 1'b1;
        else if (slot_free)
            out_valid_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            err_empty <= 1'b0;
            state     <= IDLE;
`ifdef REQ_ENC_RR_EN
            last_idx  <= 3'd7;
`endif
        end else begin
            pending   <= pending_nxt;
            out_valid <= out_valid_nxt;
            err_empty <= accept && (req_in == '0);
            if (issue) begin
                out_idx <= sel_idx;
`ifdef REQ_ENC_RR_EN
                last_idx <= sel_idx;
`endif
            end
            if (pending_nxt != '0)
                state <= ISSUE;
            else if (out_valid_nxt)
                state <= LAST;
            else
                state <= IDLE;
        end
    end
endmodule

// File: tb/tb_req_encoder8.sv
// Self-checking bench for req_encoder8: table-driven batch drains plus
// hand-written reset, backpressure, enable, empty-batch and overlap sequences.
module tb_req_encoder8;
    import req_enc_pkg::*;

    logic       clk = 1'b0;
    logic       rst, en, req_valid, out_ready;
    logic [7:0] req_in;
    logic       req_ready, out_valid, err_empty;
    logic [2:0] out_idx;
    logic [7:0] pending;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    req_encoder8 dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_in    (req_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .err_empty (err_empty)
    );

    typedef struct {
        logic [7:0]  req;
        int          n;
        logic [31:0] seq;   // expected indices, one per nibble, first in low nibble
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Accept one batch with out_ready held high and follow its drain.
    task automatic drain(input string name, input logic [7:0] req, input int n, input logic [31:0] seq);
        logic [7:0] model;
        logic [2:0] e;
        out_ready = 1'b1;
        chk({name, " ready"}, {31'd0, req_ready}, 32'd1);
        req_in    = req;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk({name, " accept_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, " accept_pend"}, {24'd0, pending}, {24'd0, req});
        model = req;
        for (int i = 0; i < n; i++) begin
            tick();
            e = seq[4*i +: 3];
            model = model & ~(8'd1 << e);
            chk({name, " valid"}, {31'd0, out_valid}, 32'd1);
            chk({name, " idx"}, {29'd0, out_idx}, {29'd0, e});
            chk({name, " pend"}, {24'd0, pending}, {24'd0, model});
        end
        tick();
        chk({name, " done_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        vec_t tv [6];
        tv[0] = '{req: 8'hA6, n: 4, seq: 32'h0000_7521};
        tv[1] = '{req: 8'h01, n: 1, seq: 32'h0000_0000};
        tv[2] = '{req: 8'h80, n: 1, seq: 32'h0000_0007};
        tv[3] = '{req: 8'hFF, n: 8, seq: 32'h7654_3210};
        tv[4] = '{req: 8'h0F, n: 4, seq: 32'h0000_3210};
        tv[5] = '{req: 8'h1F, n: 5, seq: 32'h0004_3210};

        rst = 1'b1; en = 1'b1; req_valid = 1'b0; out_ready = 1'b0; req_in = '0;

        // Reset state and mid-batch reset.
        tick(); tick();
        chk("rst pending", {24'd0, pending}, 32'd0);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out_idx", {29'd0, out_idx}, 32'd0);
        chk("rst err_empty", {31'd0, err_empty}, 32'd0);
        chk("rst req_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post rst req_ready", {31'd0, req_ready}, 32'd1);
        req_in = 8'hFF; req_valid = 1'b1; out_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        chk("midbatch idx", {29'd0, out_idx}, 32'd1);
        chk("midbatch pend", {24'd0, pending}, 32'hFC);
        rst = 1'b1;
        #1;
        chk("midbatch ready in rst", {31'd0, req_ready}, 32'd0);
        tick();
        chk("midbatch rst pend", {24'd0, pending}, 32'd0);
        chk("midbatch rst valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midbatch ready after", {31'd0, req_ready}, 32'd1);

`ifdef REQ_ENC_RR_EN
        drain("rr 0F", 8'h0F, 4, 32'h0000_3210);
        drain("rr 1F", 8'h1F, 5, 32'h0003_2104);
`else
        for (int t = 0; t < 6; t++)
            drain($sformatf("tv%0d", t), tv[t].req, tv[t].n, tv[t].seq);
`endif

        // Backpressure: index held stable while out_ready is low.
        reset_pulse();
        out_ready = 1'b0;
        req_in = 8'h81; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp valid", {31'd0, out_valid}, 32'd1);
            chk("bp idx", {29'd0, out_idx}, 32'd0);
            chk("bp pend", {24'd0, pending}, 32'h80);
        end
        out_ready = 1'b1;
        tick();
        chk("bp rel idx", {29'd0, out_idx}, 32'd7);
        chk("bp rel valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("bp end valid", {31'd0, out_valid}, 32'd0);

        // Empty batch pulses err_empty once and leaves state IDLE.
        reset_pulse();
        req_in = 8'h00; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("empty err", {31'd0, err_empty}, 32'd1);
        chk("empty pend", {24'd0, pending}, 32'd0);
        chk("empty state", {30'd0, dut.state}, {30'd0, IDLE});
        tick();
        chk("empty err clr", {31'd0, err_empty}, 32'd0);
        chk("empty out_valid", {31'd0, out_valid}, 32'd0);

        // Enable low freezes a loaded batch.
        req_in = 8'h0C; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        en = 1'b0;
        #1;
        chk("en0 ready", {31'd0, req_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("en0 valid", {31'd0, out_valid}, 32'd0);
            chk("en0 pend", {24'd0, pending}, 32'h0C);
        end
        en = 1'b1;
        tick();
        chk("en1 idx a", {29'd0, out_idx}, 32'd2);
        chk("en1 valid a", {31'd0, out_valid}, 32'd1);
        tick();
        chk("en1 idx b", {29'd0, out_idx}, 32'd3);
        tick();
        chk("en1 done", {31'd0, out_valid}, 32'd0);

        // Overlap: new batch accepted while the last index is stalled.
        reset_pulse();
        out_ready = 1'b0;
        req_in = 8'h01; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("ovl idx0", {29'd0, out_idx}, 32'd0);
        chk("ovl state last", {30'd0, dut.state}, {30'd0, LAST});
        chk("ovl ready", {31'd0, req_ready}, 32'd1);
        req_in = 8'h02; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("ovl pend", {24'd0, pending}, 32'h02);
        chk("ovl hold idx", {29'd0, out_idx}, 32'd0);
        chk("ovl hold valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("ovl idx1", {29'd0, out_idx}, 32'd1);
        chk("ovl valid1", {31'd0, out_valid}, 32'd1);
        tick();
        chk("ovl done", {31'd0, out_valid}, 32'd0);
        chk("ovl pend0", {24'd0, pending}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
